mock_tss_key_fsm: RTL
=====================

MOCK_TSS_KEY_FSM -- requirements
Module: mock_tss_key_fsm

Interface
REQ-001 The block SHALL have parameter KEY_WORDS, default 2, giving the number of key words per key (1..255).
REQ-002 The block SHALL have parameter WORD_W, default 64, giving the width of each key word in bits.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 8, giving the number of artificial wait cycles (0..255).
REQ-004 The block SHALL have parameter LOAD_ORDER, default 0, selecting word order: 0 loads low to high (word 0 into the LSBs first); 1 loads high to low.
REQ-005 Ports SHALL be as follows (clock and reset first):
  clk  in  1  clock; all state changes on the rising edge
  rst  in  1  reset; asynchronous, active-high
  key_data  in  WORD_W  key word
  key_valid  in  1  key_data is valid
  key_ready  out  1  the block accepts a word this cycle
  key_complete  out  1  the full key is loaded
  key_error  out  1  one-cycle pulse when a word is rejected
  clear_key  in  1  clear request
  clear_key_ack  out  1  one-cycle pulse when the clear is done
  key_register  out  WORD_W*KEY_WORDS  assembled key
  words_loaded  out  8  count of words accepted for the current key

Function
REQ-006 A word SHALL be accepted on a rising edge where key_valid and key_ready are both 1.
REQ-007 An accepted word SHALL be written to slice index i, where i = words_loaded if LOAD_ORDER=0 and KEY_WORDS-1-words_loaded if LOAD_ORDER=1. No other slice changes.
REQ-008 The FSM states SHALL be IDLE, LOAD_WAIT, NEXT_WORD, CLEAR and CLEAR_WAIT.
REQ-009 IDLE:
  - key_ready=1.
  - On clear_key: key_register<=0, key_complete<=0, words_loaded<=0, clear_key_ack<=1 on the next edge; the state stays IDLE.
  - Else, on key acceptance: go to LOAD_WAIT, and the wait counter <= WAIT_CYCLES.
REQ-010 LOAD_WAIT:
  - key_ready=0.
  - The counter decrements every cycle.
  - When the counter is 0: words_loaded increments.
  - If the new value equals KEY_WORDS, key_complete<=1 and the next state is IDLE; otherwise the next state is NEXT_WORD.
  - The state lasts exactly WAIT_CYCLES+1 cycles.
REQ-011 NEXT_WORD:
  - key_ready=1.
  - On key acceptance: go to LOAD_WAIT with the counter reloaded.
  - The block SHALL wait here indefinitely with no timeout.
REQ-012 A clear_key seen in LOAD_WAIT or NEXT_WORD SHALL abort the load and go to CLEAR. Clear SHALL take priority over acceptance and over the counter reaching 0 in the same cycle.
REQ-013 CLEAR:
  - key_register<=0, words_loaded<=0, key_complete<=0.
  - The counter <= WAIT_CYCLES, and the next state is CLEAR_WAIT.
  - key_ready=0.
REQ-014 CLEAR_WAIT:
  - key_ready=0.
  - The counter decrements every cycle.
  - When the counter is 0, clear_key_ack pulses for 1 cycle and the next state is IDLE.
REQ-015 With key_complete=1 and the lock feature absent, an acceptance in IDLE SHALL start a new key:
  - key_complete<=0.
  - The word is written at index 0 (LOAD_ORDER=0) or KEY_WORDS-1 (LOAD_ORDER=1).
  - words_loaded restarts from 0.
REQ-016 The counter and words_loaded SHALL never wrap. Any unreachable state encoding SHALL return to IDLE with key_register zeroed and all outputs at reset values.
REQ-017 key_error and clear_key_ack SHALL never be high for more than one consecutive cycle unless re-triggered.

Reset
REQ-018 While rst=1:
  - key_ready=1, key_complete=0, key_error=0, clear_key_ack=0.
  - key_register=0, words_loaded=0.
  - The counter = WAIT_CYCLES, and the state = IDLE.
REQ-019 Reset asserted mid-load or mid-clear SHALL discard all partial key data, with no ack issued.

Configuration
REQ-020 With MOCK_TSS_KEY_LOCK_EN defined:
  - While key_complete=1, a word presented in IDLE is acked by key_ready=1 but discarded.
  - key_error pulses for 1 cycle.
  - key_register is unchanged.
  - Only clear_key unlocks the block.
REQ-021 Without MOCK_TSS_KEY_LOCK_EN, key_error SHALL be tied to 0 and the behaviour in REQ-015 SHALL apply.

Structure
REQ-022 The state enum MOCKTSS_KEY_STATE_TYPE SHALL live in llki_pkg.
REQ-023 The reset value for the wait counter SHALL be the WAIT_CYCLES parameter, with no package constant.
REQ-024 The wait counter SHALL be a sub-module, mock_tss_wait_ctr, with load, decrement and zero-flag functions. The FSM and the assembly logic SHALL stay in the top module.

Verification
REQ-025 The bench SHALL cover these scenarios, all at WORD_W=64 and WAIT_CYCLES=4 unless stated:
  1. Basic load: KEY_WORDS=2, LOAD_ORDER=0; send 0x1111 then 0x2222. Required response: key_register=0x…2222_…1111, key_complete=1 five cycles after the second acceptance, and key_ready low for 5 cycles after each accept.
  2. Reverse order: LOAD_ORDER=1, KEY_WORDS=3; send A, B, C. Required response: key_register = {A,B,C} (A in the MSBs), words_loaded=3.
  3. Clear mid-load: clear_key during LOAD_WAIT of word 1. Required response: key_register=0, clear_key_ack pulses 6 cycles after clear_key is sampled, words_loaded=0, key_complete=0.
  4. Clear in IDLE: a 1-cycle clear. Required response: ack on the next cycle and key_register=0.
  5. Simultaneous clear_key and key_valid in NEXT_WORD. Required response: the clear wins and the word is not written.
  6. Lock feature (MOCK_TSS_KEY_LOCK_EN defined): after a complete key, send 0xDEAD. Required response: a key_error pulse and an unchanged key. Without the macro, the same stimulus restarts the load and key_complete drops.

Source files
------------

// File: rtl/llki_pkg.sv
// Shared types for the mock TSS key loader.
// Holds the FSM state enum and the word-slot helper.
package llki_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_WAIT  = 3'd1,
        ST_NEXT_WORD  = 3'd2,
        ST_CLEAR      = 3'd3,
        ST_CLEAR_WAIT = 3'd4
    } MOCKTSS_KEY_STATE_TYPE;

    // Slot that the n-th word of a key lands in.
    function automatic logic [7:0] slot_index(
        input logic [7:0] n,
        input logic [7:0] kw,
        input logic       rev
    );
        return rev ? (kw - 8'd1 - n) : n;
    endfunction

endpackage

// File: rtl/mock_tss_wait_ctr.sv
// Artificial wait counter for the key loader.
// Loads to WAIT_CYCLES, counts down, stops at zero.
module mock_tss_wait_ctr #(
    parameter int WAIT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'(WAIT_CYCLES);
        end else if (load) begin
            count <= 8'(WAIT_CYCLES);
        end else if (dec && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/mock_tss_key_fsm.sv
// Mock TSS key loader: assembles KEY_WORDS words into one key.
// Define MOCK_TSS_KEY_LOCK_EN to lock a completed key until cleared.
module mock_tss_key_fsm
    import llki_pkg::*;
#(
    parameter int KEY_WORDS   = 2,
    parameter int WORD_W      = 64,
    parameter int WAIT_CYCLES = 8,
    parameter int LOAD_ORDER  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           key_data,
    input  logic                        key_valid,
    output logic                        key_ready,
    output logic                        key_complete,
    output logic                        key_error,
    input  logic                        clear_key,
    output logic                        clear_key_ack,
    output logic [WORD_W*KEY_WORDS-1:0] key_register,
    output logic [7:0]                  words_loaded
);

`ifdef MOCK_TSS_KEY_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    MOCKTSS_KEY_STATE_TYPE state;

    logic       accept;
    logic       locked;
    logic       do_write;
    logic       ctr_load;
    logic       ctr_dec;
    logic       ctr_zero;
    logic [7:0] wr_base;
    logic [7:0] wr_idx;

    assign accept = key_valid && key_ready;
    assign locked = LOCK_EN && key_complete;

    // A finished key restarts from the first slot
    assign wr_base = (state == ST_IDLE && key_complete) ? 8'd0 : words_loaded;
    assign wr_idx  = slot_index(wr_base, 8'(KEY_WORDS), LOAD_ORDER != 0);

    always_comb begin
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        do_write = 1'b0;
        case (state)
            ST_IDLE: begin
                do_write = accept && !clear_key && !locked;
                ctr_load = do_write;
            end
            ST_LOAD_WAIT:  ctr_dec = !clear_key;
            ST_NEXT_WORD: begin
                do_write = accept && !clear_key;
                ctr_load = do_write;
            end
            ST_CLEAR:      ctr_load = 1'b1;
            ST_CLEAR_WAIT: ctr_dec  = 1'b1;
            default:       ctr_load = 1'b1;
        endcase
    end

    mock_tss_wait_ctr #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (ctr_load),
        .dec  (ctr_dec),
        .zero (ctr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            key_ready     <= 1'b1;
            key_complete  <= 1'b0;
            clear_key_ack <= 1'b0;
            key_register  <= '0;
            words_loaded  <= 8'd0;
        end else begin
            clear_key_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_key) begin
                        key_register  <= '0;
                        key_complete  <= 1'b0;
                        words_loaded  <= 8'd0;
                        clear_key_ack <= 1'b1;
                    end else if (do_write) begin
                        key_complete <= 1'b0;
                        words_loaded <= 8'd0;
                        key_ready    <= 1'b0;
                        state        <= ST_LOAD_WAIT;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (clear_key) begin
                        state <= ST_CLEAR;
                    end else if (ctr_zero) begin
                        words_loaded <= words_loaded + 8'd1;
                        key_ready    <= 1'b1;
                        if (words_loaded + 8'd1 == 8'(KEY_WORDS)) begin
                            key_complete <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            state <= ST_NEXT_WORD;
                        end
                    end
                end
                ST_NEXT_WORD: begin
                    if (clear_key) begin
                        key_ready <= 1'b0;
                        state     <= ST_CLEAR;
                    end else if (do_write) begin
                        key_ready <= 1'b0;
                        state     <= ST_LOAD_WAIT;
                    end
                end
                ST_CLEAR: begin
                    key_register <= '0;
                    words_loaded <= 8'd0;
                    key_complete <= 1'b0;
                    state        <= ST_CLEAR_WAIT;
                end
                ST_CLEAR_WAIT: begin
                    if (ctr_zero) begin
                        clear_key_ack <= 1'b1;
                        key_ready     <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    key_ready    <= 1'b1;
                    key_complete <= 1'b0;
                    key_register <= '0;
                    words_loaded <= 8'd0;
                end
            endcase
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (do_write && wr_idx == 8'(i)) begin
                    key_register[i*WORD_W +: WORD_W] <= key_data;
                end
            end
        end
    end

`ifdef MOCK_TSS_KEY_LOCK_EN
    // Word offered to a locked key: acked, dropped, flagged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_error <= 1'b0;
        end else begin
            key_error <= (state == ST_IDLE) && accept
                         && !clear_key && key_complete;
        end
    end
`else
    assign key_error = 1'b0;
`endif

endmodule
